// File: rtl/edge_row_if.sv
// Handshake bundle between the edge detector (writer), the contour tracer
// (reader) and the edge-map row arbiter.
interface edge_row_if #(
    parameter int ROW_W  = 1024,
    parameter int ADDR_W = 10
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [ROW_W-1:0]  rd_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_valid, rd_data
    );
endinterface

// File: rtl/edge_row_arbiter.sv
// Single-port BRAM arbiter between an edge-map row writer and a row reader.
// Build macro EDGE_ARB_RR_EN: round-robin tie-break (default: writer priority).
module edge_row_arbiter #(
    parameter int ROW_W  = 1024,
    parameter int ADDR_W = 10,
    parameter int ROWS   = 768,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    edge_row_if.slave         bus,
    output logic [ADDR_W:0]   rows_written,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [ROW_W-1:0]  bram_din,
    input  logic [ROW_W-1:0]  bram_dout
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT} state_t;

    localparam logic [ADDR_W:0] ROWS_C   = (ADDR_W + 1)'(ROWS);
    localparam logic [1:0]      LAT_LAST = 2'(RD_LAT - 1);

    state_t     state, state_nxt;
    logic [1:0] lat_cnt;
    logic       wr_in_range, wr_in_order, rd_elig, tie, wr_wins_tie;
    logic       grant_wr, grant_rd, capture, count_inc;

    assign wr_in_range = {1'b0, bus.wr_addr} < ROWS_C;
    assign wr_in_order = {1'b0, bus.wr_addr} == rows_written;
    // A row may only be read once it has been committed in order this frame.
    assign rd_elig     = bus.rd_req && ({1'b0, bus.rd_addr} < rows_written);
    assign tie         = bus.wr_req && rd_elig;

`ifdef EDGE_ARB_RR_EN
    logic last_wr;

    assign wr_wins_tie = !last_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_wr <= 1'b0;
        else if (tie && (grant_wr || grant_rd))
            last_wr <= grant_wr;
    end
`else
    assign wr_wins_tie = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grants are combinational and suppressed while reset is held.
    always_comb begin
        state_nxt  = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        capture    = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        bus.wr_ack = 1'b0;
        bus.rd_ack = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    if (bus.wr_req && (!tie || wr_wins_tie)) begin
                        grant_wr   = 1'b1;
                        bus.wr_ack = 1'b1;
                        bram_en    = wr_in_range;
                        bram_we    = wr_in_range;
                        bram_addr  = bus.wr_addr;
                        bram_din   = bus.wr_data;
                        state_nxt  = WRITE;
                    end else if (rd_elig) begin
                        grant_rd   = 1'b1;
                        bus.rd_ack = 1'b1;
                        bram_en    = 1'b1;
                        bram_addr  = bus.rd_addr;
                        state_nxt  = RD_WAIT;
                    end
                end
            end
            WRITE: state_nxt = IDLE;
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lat_cnt <= '0;
        else if (state == RD_WAIT && !capture)
            lat_cnt <= lat_cnt + 2'd1;
        else
            lat_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= capture;
            if (capture)
                bus.rd_data <= bram_dout;
        end
    end

    assign count_inc = grant_wr && wr_in_range && wr_in_order && (rows_written < ROWS_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rows_written <= '0;
        else if (frame_start)
            rows_written <= '0;
        else if (count_inc)
            rows_written <= rows_written + 1'b1;
    end
endmodule
